// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one slow-memory line port among NUM_CH cache miss ports.
// A request is latched into registered memory outputs, held until the one-cycle
// mem_ready, then a single RELEASE cycle lets the served cache drop its request.
module mem_port_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 28,
  parameter int LINE_W  = 128,
  parameter int RR_MODE = 1
) (
  input  logic                       clk,
  input  logic                       proc_reset,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  output logic [LINE_W-1:0]          ch_rdata,
  output logic [NUM_CH-1:0]          ch_ready,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic [LINE_W-1:0]          mem_rdata,
  input  logic                       mem_ready,
  output logic                       busy
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state;
  logic [GW-1:0]       grant;
  logic [GW-1:0]       rr_ptr;
  logic [NUM_CH-1:0]   req;
  logic                win_found;
  logic [GW-1:0]       win_idx;
  int                  cand;
  logic                sel_read;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LINE_W-1:0]   sel_wdata;

  assign req      = ch_read | ch_write;
  assign ch_rdata = mem_rdata;
  assign busy     = (state != IDLE);

  // Pick the winner: first requester at or after rr_ptr (cyclic), or lowest index in fixed mode.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (RR_MODE != 0) ? (int'(rr_ptr) + k) : k;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      if (!win_found && req[GW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
  end

  // Mux the winning channel's command; a write wins over a simultaneous read.
  always_comb begin
    sel_write = ch_write[win_idx];
    sel_read  = ch_read[win_idx] & ~ch_write[win_idx];
    sel_addr  = ch_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    sel_wdata = ch_wdata[int'(win_idx)*LINE_W +: LINE_W];
  end

  // Completion pulse is steered combinationally to the granted channel only while BUSY.
  always_comb begin
    ch_ready = '0;
    if (state == BUSY && !proc_reset) begin
      ch_ready[grant] = mem_ready;
    end
  end

  // Arbitration FSM with registered memory outputs and round-robin pointer.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant     <= win_idx;
            mem_read  <= sel_read;
            mem_write <= sel_write;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= RELEASE;
            if (RR_MODE != 0) begin
              if (int'(grant) == NUM_CH - 1) begin
                rr_ptr <= '0;
              end else begin
                rr_ptr <= grant + 1'b1;
              end
            end
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench driving a round-robin and a fixed-priority
// arbiter, with a latency-programmable memory responder per instance.
module tb_mem_port_arbiter;

  localparam int NCH = 2;
  localparam int AW  = 28;
  localparam int LW  = 128;

  typedef struct {
    int            ch;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic proc_reset;

  // index 0 = round-robin instance, index 1 = fixed-priority instance
  logic [1:0][NCH-1:0]    ch_read;
  logic [1:0][NCH-1:0]    ch_write;
  logic [1:0][NCH*AW-1:0] ch_addr;
  logic [1:0][NCH*LW-1:0] ch_wdata;
  logic [1:0][LW-1:0]     ch_rdata;
  logic [1:0][NCH-1:0]    ch_ready;
  logic [1:0]             mem_read;
  logic [1:0]             mem_write;
  logic [1:0][AW-1:0]     mem_addr;
  logic [1:0][LW-1:0]     mem_wdata;
  logic [LW-1:0]          resp_data;
  logic [1:0]             mem_ready;
  logic [1:0]             busy;

  exp_t                q0[$];
  exp_t                q1[$];
  exp_t                cur[2];
  bit   [1:0]          cur_valid;
  logic [1:0]          prev_act;
  logic [1:0][NCH-1:0] prev_rdy;
  bit   [1:0][NCH-1:0] keep;
  bit   [1:0][NCH-1:0] pend_drop;
  int                  lat[2];
  int                  cnt[2];
  int                  done_cnt[2];
  int                  rise_cyc[$];
  int                  rdy_cyc[$];
  int                  cyc;
  int                  checks;
  int                  fails;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1)) dut_rr (
    .clk(clk), .proc_reset(proc_reset),
    .ch_read(ch_read[0]), .ch_write(ch_write[0]), .ch_addr(ch_addr[0]), .ch_wdata(ch_wdata[0]),
    .ch_rdata(ch_rdata[0]), .ch_ready(ch_ready[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(resp_data), .mem_ready(mem_ready[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(0)) dut_fp (
    .clk(clk), .proc_reset(proc_reset),
    .ch_read(ch_read[1]), .ch_write(ch_write[1]), .ch_addr(ch_addr[1]), .ch_wdata(ch_wdata[1]),
    .ch_rdata(ch_rdata[1]), .ch_ready(ch_ready[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(resp_data), .mem_ready(mem_ready[1]), .busy(busy[1])
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one channel's request lines on one instance.
  task automatic applyStimulus(input bit k, input bit ch, input logic rd, input logic wr,
                               input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
    ch_read[k][ch]              = rd;
    ch_write[k][ch]             = wr;
    ch_addr[k][ch*AW +: AW]     = addr;
    ch_wdata[k][ch*LW +: LW]    = wdata;
  endtask

  // Push the next transaction the instance must issue to memory.
  task automatic expectTxn(input bit k, input int ch, input logic rd, input logic wr,
                           input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
    exp_t e;
    e.ch = ch; e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = resp_data;
    if (k == 1'b0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  // One clock: monitor/scoreboard at negedge, then cache drops and memory responder after posedge.
  task automatic tick();
    exp_t          e;
    bit            got;
    bit            kb;
    logic          act;
    logic [NCH-1:0] oh;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      kb  = k[0];
      act = mem_read[kb] | mem_write[kb];
      if (act && !prev_act[kb]) begin
        got = 1'b0;
        if (kb == 1'b0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
        if (kb == 1'b1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
        if (!got) begin
          checkOutput("unexpected_req", LW'(act), '0);
        end else begin
          checkOutput("req_addr",  LW'(mem_addr[kb]),  LW'(e.addr));
          checkOutput("req_wdata", mem_wdata[kb],      e.wdata);
          checkOutput("req_read",  LW'(mem_read[kb]),  LW'(e.rd));
          checkOutput("req_write", LW'(mem_write[kb]), LW'(e.wr));
          cur[kb] = e;
          cur_valid[kb] = 1'b1;
          if (kb == 1'b0) rise_cyc.push_back(cyc);
        end
      end
      prev_act[kb] = act;
      if (ch_ready[kb] != '0) begin
        checkOutput("ready_width", LW'(prev_rdy[kb]), '0);
        if (!cur_valid[kb]) begin
          checkOutput("stray_ready", LW'(ch_ready[kb]), '0);
        end else begin
          oh = NCH'(1) << cur[kb].ch;
          checkOutput("ready_chan",  LW'(ch_ready[kb]), LW'(oh));
          checkOutput("ready_rdata", ch_rdata[kb], cur[kb].rdata);
          cur_valid[kb] = 1'b0;
          done_cnt[kb]++;
          if (kb == 1'b0) rdy_cyc.push_back(cyc);
          if ((kb == 1'b0 && q0.size() == 0) || (kb == 1'b1 && q1.size() == 0))
            pend_drop[kb] = '1;
          else if (!keep[kb][cur[kb].ch[0]])
            pend_drop[kb][cur[kb].ch[0]] = 1'b1;
        end
      end
      prev_rdy[kb] = ch_ready[kb];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      kb = k[0];
      ch_read[kb]  = ch_read[kb]  & ~pend_drop[kb];
      ch_write[kb] = ch_write[kb] & ~pend_drop[kb];
      pend_drop[kb] = '0;
      if (mem_ready[kb]) begin
        mem_ready[kb] = 1'b0;
      end else if (lat[kb] > 0 && (mem_read[kb] | mem_write[kb])) begin
        cnt[kb]++;
        if (cnt[kb] >= lat[kb]) begin
          mem_ready[kb] = 1'b1;
          cnt[kb] = 0;
        end
      end else begin
        cnt[kb] = 0;
      end
    end
  endtask

  // Tick until both scoreboards drain and both arbiters are idle, bounded by a cycle budget.
  task automatic waitDone(input int budget);
    bit pending;
    pending = 1'b1;
    for (int i = 0; i < budget && pending; i++) begin
      tick();
      pending = (q0.size() != 0) || (q1.size() != 0) || (cur_valid != '0) || (busy != '0);
    end
    if (pending) checkOutput("wait_timeout", LW'(pending), '0);
  endtask

  // Synchronous reset of both instances and of the bench's tracking state.
  task automatic resetDut();
    proc_reset = 1'b1;
    ch_read = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0;
    mem_ready = '0;
    tick();
    tick();
    proc_reset = 1'b0;
    q0.delete(); q1.delete(); rise_cyc.delete(); rdy_cyc.delete();
    cur_valid = '0; prev_act = '0; prev_rdy = '0; keep = '0; pend_drop = '0;
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; done_cnt[k] = 0; lat[k] = 2;
    end
  endtask

  localparam logic [LW-1:0] WD4 = 128'h0123456789ABCDEF0123456789ABCDEF;

  initial begin
    checks = 0; fails = 0; cyc = 0;
    resp_data = '0;
    proc_reset = 1'b1;
    ch_read = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0; mem_ready = '0;
    cur_valid = '0; prev_act = '0; prev_rdy = '0; keep = '0; pend_drop = '0;
    for (int k = 0; k < 2; k++) begin cnt[k] = 0; done_cnt[k] = 0; lat[k] = 2; end

    // reset state
    resetDut();
    checkOutput("rst_mem_read",  LW'(mem_read[0]),  '0);
    checkOutput("rst_mem_write", LW'(mem_write[0]), '0);
    checkOutput("rst_mem_addr",  LW'(mem_addr[0]),  '0);
    checkOutput("rst_mem_wdata", mem_wdata[0],      '0);
    checkOutput("rst_ch_ready",  LW'(ch_ready[0]),  '0);
    checkOutput("rst_busy",      LW'(busy[0]),      '0);

    // single ch1 read, latency 4
    resp_data = {16{8'hA5}};
    lat[0] = 4;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 28'h0000123, '0);
    expectTxn(1'b0, 1, 1'b1, 1'b0, 28'h0000123, '0);
    checkOutput("t1_not_yet", LW'(mem_read[0]), '0);
    tick();
    checkOutput("t1_mem_read", LW'(mem_read[0]), LW'(1'b1));
    checkOutput("t1_mem_addr", LW'(mem_addr[0]), LW'(28'h0000123));
    waitDone(50);
    checkOutput("t1_ready_count", LW'(rdy_cyc.size()), LW'(1));

    // simultaneous pair from reset, then round-robin order flips after a ch0 service
    resetDut();
    resp_data = {8{16'h1111}};
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 28'h0000010, {4{32'h00000A00}});
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 28'h0000011, {4{32'h00000A01}});
    expectTxn(1'b0, 0, 1'b1, 1'b0, 28'h0000010, {4{32'h00000A00}});
    expectTxn(1'b0, 1, 1'b1, 1'b0, 28'h0000011, {4{32'h00000A01}});
    waitDone(60);
    if (rise_cyc.size() == 2 && rdy_cyc.size() == 2)
      checkOutput("t2_release_gap", LW'(rise_cyc[1] - rdy_cyc[0]), LW'(3));
    else
      checkOutput("t2_txn_count", LW'(rise_cyc.size()), LW'(2));
    resp_data = {8{16'h2222}};
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 28'h0000012, '0);
    expectTxn(1'b0, 0, 1'b1, 1'b0, 28'h0000012, '0);
    waitDone(40);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 28'h0000020, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 28'h0000021, '0);
    expectTxn(1'b0, 1, 1'b1, 1'b0, 28'h0000021, '0);
    expectTxn(1'b0, 0, 1'b1, 1'b0, 28'h0000020, '0);
    waitDone(60);

    // continuous contention: RR alternates, fixed priority starves ch1
    resetDut();
    resp_data = {8{16'h3C3C}};
    keep = '1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(k[0], 1'b0, 1'b1, 1'b0, 28'h0000030, '0);
      applyStimulus(k[0], 1'b1, 1'b1, 1'b0, 28'h0000031, '0);
    end
    for (int i = 0; i < 8; i++)
      expectTxn(1'b0, i % 2, 1'b1, 1'b0, (i % 2 == 0) ? 28'h0000030 : 28'h0000031, '0);
    for (int i = 0; i < 20; i++)
      expectTxn(1'b1, 0, 1'b1, 1'b0, 28'h0000030, '0);
    waitDone(400);
    checkOutput("t3_rr_done", LW'(done_cnt[0]), LW'(8));
    checkOutput("t3_fp_done", LW'(done_cnt[1]), LW'(20));

    // write with exact addr/data, and wdata change during BUSY must not leak through
    resetDut();
    lat[0] = 6;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 28'h0FFFFFF, WD4);
    expectTxn(1'b0, 0, 1'b0, 1'b1, 28'h0FFFFFF, WD4);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 28'h0000000, ~WD4);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t4_wdata_hold", mem_wdata[0], WD4);
      checkOutput("t4_addr_hold",  LW'(mem_addr[0]), LW'(28'h0FFFFFF));
    end
    waitDone(40);

    // reset during BUSY abandons the transaction; a late mem_ready gives no pulse
    resetDut();
    lat[0] = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 28'h0000055, '0);
    expectTxn(1'b0, 0, 1'b1, 1'b0, 28'h0000055, '0);
    tick();
    tick();
    checkOutput("t5_busy", LW'(busy[0]), LW'(1'b1));
    proc_reset = 1'b1;
    ch_read = '0;
    tick();
    proc_reset = 1'b0;
    cur_valid[0] = 1'b0;
    checkOutput("t5_mem_read", LW'(mem_read[0]), '0);
    checkOutput("t5_busy_low", LW'(busy[0]), '0);
    mem_ready[0] = 1'b1;
    #1;
    checkOutput("t5_no_ready", LW'(ch_ready[0]), '0);
    tick();
    tick();

    // stray mem_ready in IDLE, then read+write on ch1 resolves to a write
    resetDut();
    mem_ready[0] = 1'b1;
    #1;
    checkOutput("t6_stray_idle", LW'(ch_ready[0]), '0);
    tick();
    lat[0] = 2;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 28'h0ABCDEF, {4{32'hFEEDBEEF}});
    expectTxn(1'b0, 1, 1'b0, 1'b1, 28'h0ABCDEF, {4{32'hFEEDBEEF}});
    mem_ready[0] = 1'b1;
    #1;
    checkOutput("t6_stray_req", LW'(ch_ready[0]), '0);
    waitDone(40);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
